// File: rtl/control_escaneo_teclado_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding and the
// width helper that consumers of `codigo` use to size their code bus.
package control_escaneo_teclado_pkg;

  // FSM state encoding. The constants are plain logic vectors so that older
  // tools and code that compares against raw values still work.
  localparam logic [1:0] SCAN         = 2'd0;
  localparam logic [1:0] DEBOUNCE     = 2'd1;
  localparam logic [1:0] EMIT         = 2'd2;
  localparam logic [1:0] WAIT_RELEASE = 2'd3;

  // Ceiling log2. Returns at least 1 so that single-entry ranges still
  // produce a usable 1-bit vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 1;
    while ((64'd1 << width) < 64'(value)) width = width + 1;
    return width;
  endfunction

endpackage

// File: rtl/control_escaneo_teclado_if.sv
// Code delivery channel from the keypad scanner to its consumer.
//   codigo        : key code, row*N_COLS + col
//   codigo_valido : code available (valid)
//   codigo_listo  : consumer accepts the code (ready)
// master = scanner side, slave = consumer side.
interface control_escaneo_teclado_if
  import control_escaneo_teclado_pkg::*;
#(
  parameter int unsigned CODE_W = clog2(16)
);

  logic [CODE_W-1:0] codigo;
  logic              codigo_valido;
  logic              codigo_listo;

  modport master (
    output codigo,
    output codigo_valido,
    input  codigo_listo
  );

  modport slave (
    input  codigo,
    input  codigo_valido,
    output codigo_listo
  );

endinterface

// File: rtl/control_escaneo_teclado_sincronizador_2ff.sv
// Two-flop synchronizer for an N-bit bus of asynchronous inputs.
//   clk, rst_n : clock and async active-low reset
//   d          : asynchronous input bus
//   q          : synchronized output bus (two cycles of latency)
// Both stages reset to all ones when RESET_ONES=1 (idle level of pulled-up
// lines), otherwise to all zeros.
module sincronizador_2ff #(
  parameter int unsigned W          = 4,
  parameter bit          RESET_ONES = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  // Metastability stage followed by the output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= {W{RESET_ONES}};
      q    <= {W{RESET_ONES}};
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/control_escaneo_teclado.sv
// Matrix keypad scanner. Drives one column low at a time, samples the
// (active-low) row lines, debounces a single pressed key and hands its code
// to the consumer over a valid/ready channel. One event per press.
//   clk, rst_n        : clock, async active-low reset
//   fila_in           : raw row lines, active-low, asynchronous
//   col_out           : column drive, one-hot active-low
//   tecla_presionada  : debounced key currently held
//   error_multiple    : 1-cycle pulse when a sample shows more than one row low
//   bus (master)      : codigo / codigo_valido / codigo_listo
module control_escaneo_teclado
  import control_escaneo_teclado_pkg::*;
#(
  parameter int unsigned N_COLS       = 4,
  parameter int unsigned N_ROWS       = 4,
  parameter int unsigned SETTLE_CYC   = 1000,
  parameter int unsigned DEBOUNCE_CYC = 6_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_ROWS-1:0]     fila_in,
  output logic [N_COLS-1:0]     col_out,
  output logic                  tecla_presionada,
  output logic                  error_multiple,
  control_escaneo_teclado_if.master bus
);

  localparam int unsigned CODE_W  = clog2(N_ROWS * N_COLS);
  localparam int unsigned COL_W   = clog2(N_COLS);
  localparam int unsigned ROW_W   = clog2(N_ROWS);
  localparam int unsigned ZC_W    = ROW_W + 1;
  localparam int unsigned CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int unsigned CNT_W   = clog2(CNT_MAX + 1);

  logic [N_ROWS-1:0] fila_s;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [COL_W-1:0]  col_idx_q, col_idx_d, col_wrap;
  logic [N_COLS-1:0] col_out_d;
  logic [ROW_W-1:0]  fila_cap_q, fila_cap_d;
  logic [N_ROWS-1:0] patron_q, patron_d;
  logic [CODE_W-1:0] codigo_q, codigo_d, codigo_calc;
  logic              valido_q, valido_d;
  logic              tecla_d;
  logic              error_d;

  logic [ZC_W-1:0]   zeros;
  logic [ROW_W-1:0]  zero_row;

  sincronizador_2ff #(
    .W          (N_ROWS),
    .RESET_ONES (1'b1)
  ) u_sync_filas (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (fila_in),
    .q     (fila_s)
  );

  assign bus.codigo        = codigo_q;
  assign bus.codigo_valido = valido_q;

  // Number of rows pulled low and the index of the (last) low row.
  always_comb begin
    zeros    = '0;
    zero_row = '0;
    for (int i = 0; i < int'(N_ROWS); i++) begin
      if (!fila_s[i]) begin
        zeros    = zeros + ZC_W'(1);
        zero_row = ROW_W'(i);
      end
    end
  end

  // Shared arithmetic: counter increment, wrapped next column, key code.
  always_comb begin
    cnt_inc     = cnt_q + CNT_W'(1);
    col_wrap    = (col_idx_q == COL_W'(N_COLS - 1)) ? '0 : col_idx_q + COL_W'(1);
    codigo_calc = CODE_W'(CODE_W'(fila_cap_q) * CODE_W'(N_COLS)) + CODE_W'(col_idx_q);
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    col_idx_d  = col_idx_q;
    fila_cap_d = fila_cap_q;
    patron_d   = patron_q;
    codigo_d   = codigo_q;
    valido_d   = valido_q;
    tecla_d    = tecla_presionada;
    error_d    = 1'b0;

    case (state_q)
      SCAN: begin
        if (cnt_q >= CNT_W'(SETTLE_CYC)) begin
          cnt_d = '0;
          if (zeros == ZC_W'(1)) begin
            // Single key on this column: keep driving it while debouncing.
            state_d    = DEBOUNCE;
            fila_cap_d = zero_row;
            patron_d   = fila_s;
          end else begin
            col_idx_d = col_wrap;
            if (zeros > ZC_W'(1)) error_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DEBOUNCE: begin
        if (fila_s == patron_q) begin
          if (cnt_inc >= CNT_W'(DEBOUNCE_CYC)) begin
            state_d  = EMIT;
            cnt_d    = '0;
            codigo_d = codigo_calc;
            valido_d = 1'b1;
            tecla_d  = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          // Bounce: rescan the same column from a fresh settle period.
          cnt_d   = '0;
          state_d = SCAN;
        end
      end

      EMIT: begin
        // Rows are ignored here; the event completes even if the key is gone.
        if (bus.codigo_listo) begin
          valido_d = 1'b0;
          state_d  = WAIT_RELEASE;
          cnt_d    = '0;
        end
      end

      WAIT_RELEASE: begin
        if (&fila_s) begin
          if (cnt_inc >= CNT_W'(DEBOUNCE_CYC)) begin
            tecla_d   = 1'b0;
            col_idx_d = col_wrap;
            state_d   = SCAN;
            cnt_d     = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end else begin
          cnt_d = '0;
        end
      end

      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase

    col_out_d = ~(N_COLS'(1) << col_idx_d);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= SCAN;
      cnt_q            <= '0;
      col_idx_q        <= '0;
      col_out          <= ~(N_COLS'(1));
      fila_cap_q       <= '0;
      patron_q         <= '1;
      codigo_q         <= '0;
      valido_q         <= 1'b0;
      tecla_presionada <= 1'b0;
      error_multiple   <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      col_idx_q        <= col_idx_d;
      col_out          <= col_out_d;
      fila_cap_q       <= fila_cap_d;
      patron_q         <= patron_d;
      codigo_q         <= codigo_d;
      valido_q         <= valido_d;
      tecla_presionada <= tecla_d;
      error_multiple   <= error_d;
    end
  end

endmodule

// File: tb/tb_control_escaneo_teclado.sv
// Directed bench for control_escaneo_teclado with SETTLE_CYC=4,
// DEBOUNCE_CYC=16. A keypad model pulls row r low whenever key (r,c) is
// held and column c is driven low.
module tb_control_escaneo_teclado;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  fila_in;
  logic [3:0]  col_out;
  logic        tecla;
  logic        err;
  logic [15:0] keys;

  int total = 0;
  int bad   = 0;

  int         xfer_cnt = 0;
  int         vhi_cnt  = 0;
  int         err_hi   = 0;
  int         err_rise = 0;
  logic       err_prev = 1'b0;
  logic [3:0] last_code = 4'h0;

  control_escaneo_teclado_if #(.CODE_W(4)) bus ();

  control_escaneo_teclado #(
    .N_COLS       (4),
    .N_ROWS       (4),
    .SETTLE_CYC   (4),
    .DEBOUNCE_CYC (16)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fila_in          (fila_in),
    .col_out          (col_out),
    .tecla_presionada (tecla),
    .error_multiple   (err),
    .bus              (bus)
  );

  always #5 clk = ~clk;

  // Keypad model: key index = row*4 + col.
  always_comb begin
    fila_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_out[c]) fila_in[r] = 1'b0;
  end

  // Event monitors.
  always @(posedge clk) begin
    if (bus.codigo_valido && bus.codigo_listo) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_code <= bus.codigo;
    end
    if (bus.codigo_valido) vhi_cnt <= vhi_cnt + 1;
    if (err) err_hi <= err_hi + 1;
    if (err && !err_prev) err_rise <= err_rise + 1;
    err_prev <= err;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valido(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (bus.codigo_valido) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_release(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!tecla) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] exp_seq [4];
    logic [3:0] prev;
    bit         ok;
    bit         changed;
    bit         seen;
    int         n;
    int         base_x;
    int         base_v;
    int         base_eh;
    int         base_er;

    exp_seq = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    // Reset values.
    rst_n            = 1'b0;
    keys             = 16'h0;
    bus.codigo_listo = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_col_out", 32'(col_out), 32'(4'b1110));
    check("rst_valido", 32'(bus.codigo_valido), 32'd0);
    check("rst_codigo", 32'(bus.codigo), 32'd0);
    check("rst_tecla", 32'(tecla), 32'd0);
    check("rst_error", 32'(err), 32'd0);

    // Idle scan; ready asserted while nothing is valid must do nothing.
    rst_n            = 1'b1;
    bus.codigo_listo = 1'b1;
    prev             = col_out;
    for (int k = 0; k < 4; k++) begin
      n       = 0;
      changed = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        n++;
        if (col_out != prev) begin
          changed = 1'b1;
          break;
        end
      end
      check("scan_step", 32'(changed), 32'd1);
      check("scan_col", 32'(col_out), 32'(exp_seq[k]));
      if (k > 0) check("scan_hold", 32'(n), 32'd5);
      prev = col_out;
    end
    check("idle_no_valido", 32'(vhi_cnt), 32'd0);

    // Key row2/col1 with ready high: one transfer of code 9.
    base_x  = xfer_cnt;
    keys[9] = 1'b1;
    wait_valido(200, ok);
    check("k9_valido", 32'(ok), 32'd1);
    check("k9_codigo", 32'(bus.codigo), 32'd9);
    check("k9_tecla", 32'(tecla), 32'd1);
    @(negedge clk);
    check("k9_valido_drop", 32'(bus.codigo_valido), 32'd0);
    repeat (30) @(negedge clk);
    check("k9_tecla_held", 32'(tecla), 32'd1);
    keys = 16'h0;
    repeat (10) @(negedge clk);
    check("k9_tecla_early", 32'(tecla), 32'd1);
    wait_release(40, ok);
    check("k9_release", 32'(ok), 32'd1);
    check("k9_xfers", 32'(xfer_cnt - base_x), 32'd1);
    check("k9_last", 32'(last_code), 32'd9);

    // Key row0/col3 with ready low: code held stable, released mid-wait.
    bus.codigo_listo = 1'b0;
    base_x  = xfer_cnt;
    keys[3] = 1'b1;
    wait_valido(200, ok);
    check("k3_valido", 32'(ok), 32'd1);
    check("k3_codigo", 32'(bus.codigo), 32'd3);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i == 20) keys = 16'h0;
      check("k3_hold_valido", 32'(bus.codigo_valido), 32'd1);
      check("k3_hold_codigo", 32'(bus.codigo), 32'd3);
    end
    check("k3_no_xfer_yet", 32'(xfer_cnt - base_x), 32'd0);
    bus.codigo_listo = 1'b1;
    @(negedge clk);
    check("k3_valido_drop", 32'(bus.codigo_valido), 32'd0);
    check("k3_xfers", 32'(xfer_cnt - base_x), 32'd1);
    check("k3_last", 32'(last_code), 32'd3);
    wait_release(40, ok);
    check("k3_release", 32'(ok), 32'd1);
    repeat (40) @(negedge clk);
    check("k3_single", 32'(xfer_cnt - base_x), 32'd1);

    // Bouncing key row1/col2 (code 6), then held stable.
    base_x = xfer_cnt;
    repeat (4) begin
      keys[6] = 1'b1;
      repeat (5) @(negedge clk);
      keys[6] = 1'b0;
      repeat (5) @(negedge clk);
    end
    check("bounce_no_event", 32'(xfer_cnt - base_x), 32'd0);
    keys[6] = 1'b1;
    wait_valido(200, ok);
    check("k6_valido", 32'(ok), 32'd1);
    check("k6_codigo", 32'(bus.codigo), 32'd6);
    keys = 16'h0;
    wait_release(60, ok);
    check("k6_release", 32'(ok), 32'd1);
    check("k6_single", 32'(xfer_cnt - base_x), 32'd1);

    // Two rows low on column 0: error pulses, scanning keeps going.
    base_x   = xfer_cnt;
    base_eh  = err_hi;
    base_er  = err_rise;
    seen     = 1'b0;
    keys[4]  = 1'b1;
    keys[12] = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (col_out == 4'b0111) seen = 1'b1;
    end
    keys = 16'h0;
    @(negedge clk);
    check("multi_err_seen", 32'((err_hi - base_eh) > 0), 32'd1);
    check("multi_err_1cyc", 32'(err_hi - base_eh), 32'(err_rise - base_er));
    check("multi_no_xfer", 32'(xfer_cnt - base_x), 32'd0);
    check("multi_scan_on", 32'(seen), 32'd1);

    // Reset while a code is pending.
    bus.codigo_listo = 1'b0;
    keys[15] = 1'b1;
    wait_valido(200, ok);
    check("k15_valido", 32'(ok), 32'd1);
    check("k15_codigo", 32'(bus.codigo), 32'd15);
    rst_n = 1'b0;
    keys  = 16'h0;
    #1;
    check("arst_valido", 32'(bus.codigo_valido), 32'd0);
    check("arst_tecla", 32'(tecla), 32'd0);
    check("arst_col_out", 32'(col_out), 32'(4'b1110));
    check("arst_codigo", 32'(bus.codigo), 32'd0);
    repeat (3) @(negedge clk);
    rst_n            = 1'b1;
    bus.codigo_listo = 1'b1;
    base_x = xfer_cnt;
    base_v = vhi_cnt;
    repeat (100) @(negedge clk);
    check("arst_no_xfer", 32'(xfer_cnt - base_x), 32'd0);
    check("arst_no_valido", 32'(vhi_cnt - base_v), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
